// File: rtl/spi_ctrl_pkg.sv
// Shared constants and FSM state type for the SPI register controller.
package spi_ctrl_pkg;

    localparam logic [7:0] CMD_WRITE  = 8'h01;
    localparam logic [7:0] CMD_READ   = 8'h02;
    localparam logic [7:0] CMD_STATUS = 8'h03;

    localparam logic [7:0] ACK     = 8'hA5;
    localparam logic [7:0] NAK     = 8'hEE;
    localparam logic [7:0] IDLE_TX = 8'hC3;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        RDATA,
        WDATA,
        STAT,
        ERR
    } state_t;

endpackage

// File: rtl/spi_reg_ctrl_if.sv
// Byte-stream and register-side signals between the SPI slave, controller and fabric.
interface spi_reg_ctrl_if #(
    parameter int ADDR_W = 4
);
    logic              cs;
    logic              rxd_flag;
    logic [7:0]        rxd_out;
    logic [7:0]        txd_data;
    logic [7:0]        ctrl_reg;
    logic              led_state;
    logic              wr_pulse;
    logic [ADDR_W-1:0] wr_addr;

    modport slave (
        input  cs, rxd_flag, rxd_out,
        output txd_data, ctrl_reg, led_state, wr_pulse, wr_addr
    );

    modport master (
        output cs, rxd_flag, rxd_out,
        input  txd_data, ctrl_reg, led_state, wr_pulse, wr_addr
    );
endinterface

// File: rtl/spi_reg_ctrl_cs_sync.sv
// Two-flop synchronizer for the raw chip select, plus edge pulses on the synced level.
module cs_sync (
    input  logic clk_30M,
    input  logic rst,
    input  logic cs,
    output logic cs_fall,
    output logic cs_rise
);
    logic meta;
    logic sync;
    logic prev;

    // Reset to "deselected" so a pin already low after reset reads as a fresh fall.
    always_ff @(posedge clk_30M or negedge rst) begin
        if (!rst) begin
            meta <= 1'b1;
            sync <= 1'b1;
            prev <= 1'b1;
        end else begin
            meta <= cs;
            sync <= meta;
            prev <= sync;
        end
    end

    assign cs_fall = prev & ~sync;
    assign cs_rise = ~prev & sync;
endmodule

// File: rtl/spi_reg_ctrl.sv
// Frames the SPI byte stream into command/address/burst transactions on a flop register bank.
module spi_reg_ctrl
    import spi_ctrl_pkg::*;
#(
    parameter int         NREG    = 16,
    parameter logic [7:0] ID_VAL  = 8'h5A,
    parameter logic [3:0] VERSION = 4'h1
) (
    input  logic         clk_30M,
    input  logic         rst,
    spi_reg_ctrl_if.slave bus
);
    localparam int                ADDR_W  = $clog2(NREG);
    localparam logic [ADDR_W-1:0] ID_ADDR = ADDR_W'(NREG - 1);

    state_t            state, state_next;
    logic [7:0]        bank [NREG];
    logic [ADDR_W-1:0] addr, addr_next;
    logic [ADDR_W-1:0] wr_addr, wr_addr_next;
    logic [ADDR_W-1:0] byte_addr, rd_sel;
    logic [7:0]        txd, txd_next, rd_data;
    logic              is_read, is_read_next;
    logic              err_sticky, err_next;
    logic              wr_en, wr_pulse;
    logic              cs_fall, cs_rise;

    cs_sync u_cs_sync (
        .clk_30M (clk_30M),
        .rst     (rst),
        .cs      (bus.cs),
        .cs_fall (cs_fall),
        .cs_rise (cs_rise)
    );

    assign byte_addr = bus.rxd_out[ADDR_W-1:0];
    assign rd_sel    = (state == ADDR) ? byte_addr : addr;
    assign rd_data   = (rd_sel == ID_ADDR) ? ID_VAL : bank[rd_sel];

    always_comb begin
        state_next   = state;
        addr_next    = addr;
        wr_addr_next = wr_addr;
        txd_next     = txd;
        is_read_next = is_read;
        err_next     = err_sticky;
        wr_en        = 1'b0;
        case (state)
            IDLE: if (cs_fall) state_next = CMD;
            CMD: if (bus.rxd_flag) begin
                case (bus.rxd_out)
                    CMD_WRITE, CMD_READ: begin
                        state_next   = ADDR;
                        txd_next     = ACK;
                        is_read_next = (bus.rxd_out == CMD_READ);
                    end
                    CMD_STATUS: begin
                        state_next = STAT;
                        txd_next   = {VERSION, 3'b000, err_sticky};
                        err_next   = 1'b0;
                    end
                    default: begin
                        state_next = ERR;
                        txd_next   = NAK;
                        err_next   = 1'b1;
                    end
                endcase
            end
            ADDR: if (bus.rxd_flag) begin
                if (is_read) begin
                    state_next = RDATA;
                    txd_next   = rd_data;
                    addr_next  = byte_addr + 1'b1;
                end else begin
                    state_next = WDATA;
                    txd_next   = ACK;
                    addr_next  = byte_addr;
                end
            end
            RDATA: if (bus.rxd_flag) begin
                txd_next  = rd_data;
                addr_next = addr + 1'b1;
            end
            WDATA: if (bus.rxd_flag) begin
                wr_en        = 1'b1;
                wr_addr_next = addr;
                txd_next     = bus.rxd_out;
                addr_next    = addr + 1'b1;
            end
            default: ;
        endcase
        // A byte landing with the synced rise is still processed above; only the state is overridden.
        if (cs_rise) state_next = IDLE;
    end

    always_ff @(posedge clk_30M or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_ff @(posedge clk_30M or negedge rst) begin
        if (!rst) begin
            txd        <= IDLE_TX;
            addr       <= '0;
            wr_addr    <= '0;
            is_read    <= 1'b0;
            err_sticky <= 1'b0;
            wr_pulse   <= 1'b0;
        end else begin
            txd        <= txd_next;
            addr       <= addr_next;
            wr_addr    <= wr_addr_next;
            is_read    <= is_read_next;
            err_sticky <= err_next;
            wr_pulse   <= wr_en;
        end
    end

    // The ID register is read-only: its write still strobes wr_pulse but never lands.
    always_ff @(posedge clk_30M or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) bank[i] <= '0;
        end else if (wr_en && addr != ID_ADDR) begin
            bank[addr] <= bus.rxd_out;
        end
    end

    assign bus.txd_data  = txd;
    assign bus.ctrl_reg  = bank[0];
    assign bus.led_state = bank[0][0];
    assign bus.wr_pulse  = wr_pulse;
    assign bus.wr_addr   = wr_addr;
endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed frames against a byte-index model of the controller, checked every cycle.
module tb_spi_reg_ctrl;
    import spi_ctrl_pkg::*;

    logic clk_30M = 1'b0;
    logic rst;
    always #5 clk_30M = ~clk_30M;

    spi_reg_ctrl_if bus ();

    spi_reg_ctrl dut (
        .clk_30M (clk_30M),
        .rst     (rst),
        .bus     (bus)
    );

    int         checks;
    int         errors;
    bit         check_en;
    logic [7:0] m_bank [16];
    logic       m_err;
    logic [3:0] m_addr;
    logic [7:0] fr_cmd;
    int         fr_idx;
    logic [7:0] exp_txd;
    logic       exp_wr_pulse;
    logic [3:0] exp_wr_addr;
    logic [7:0] q [$];
    logic [7:0] txd_hist [$];

    task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_read(input logic [3:0] a);
        return (a == 4'hF) ? 8'h5A : m_bank[a];
    endfunction

    task automatic model_reset();
        foreach (m_bank[i]) m_bank[i] = 8'h00;
        m_err        = 1'b0;
        m_addr       = 4'h0;
        exp_txd      = 8'hC3;
        exp_wr_pulse = 1'b0;
        exp_wr_addr  = 4'h0;
    endtask

    // Byte 0 of a frame is the command, byte 1 the address, the rest are burst data.
    task automatic model_byte(input logic [7:0] b);
        if (fr_idx == 0) begin
            fr_cmd = b;
            if (b == 8'h01 || b == 8'h02) exp_txd = 8'hA5;
            else if (b == 8'h03) begin
                exp_txd = {4'h1, 3'b000, m_err};
                m_err   = 1'b0;
            end else begin
                exp_txd = 8'hEE;
                m_err   = 1'b1;
            end
        end else if (fr_cmd == 8'h02) begin
            if (fr_idx == 1) m_addr = b[3:0];
            exp_txd = m_read(m_addr);
            m_addr  = m_addr + 4'd1;
        end else if (fr_cmd == 8'h01) begin
            if (fr_idx == 1) begin
                m_addr  = b[3:0];
                exp_txd = 8'hA5;
            end else begin
                if (m_addr != 4'hF) m_bank[m_addr] = b;
                exp_wr_pulse = 1'b1;
                exp_wr_addr  = m_addr;
                exp_txd      = b;
                m_addr       = m_addr + 4'd1;
            end
        end
        fr_idx++;
    endtask

    always @(negedge clk_30M) begin
        if (check_en) begin
            check_output("txd_data", bus.txd_data, exp_txd);
            check_output("wr_pulse", {7'b0, bus.wr_pulse}, {7'b0, exp_wr_pulse});
            check_output("wr_addr", {4'b0, bus.wr_addr}, {4'b0, exp_wr_addr});
            check_output("ctrl_reg", bus.ctrl_reg, m_bank[0]);
            check_output("led_state", {7'b0, bus.led_state}, {7'b0, m_bank[0][0]});
        end
    end

    task automatic apply_stimulus(input logic [7:0] b, input bit in_frame);
        @(posedge clk_30M); #1;
        bus.rxd_out  = b;
        bus.rxd_flag = 1'b1;
        @(posedge clk_30M); #1;
        bus.rxd_flag = 1'b0;
        if (in_frame) model_byte(b);
        txd_hist.push_back(bus.txd_data);
        @(posedge clk_30M); #1;
        exp_wr_pulse = 1'b0;
    endtask

    task automatic frame_begin();
        @(posedge clk_30M); #1;
        bus.cs = 1'b0;
        fr_idx = 0;
        txd_hist.delete();
        repeat (4) @(posedge clk_30M);
    endtask

    task automatic frame_end();
        @(posedge clk_30M); #1;
        bus.cs = 1'b1;
        repeat (5) @(posedge clk_30M);
    endtask

    task automatic send_frame();
        frame_begin();
        foreach (q[i]) apply_stimulus(q[i], 1'b1);
        frame_end();
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        check_en     = 1'b0;
        rst          = 1'b0;
        bus.cs       = 1'b1;
        bus.rxd_flag = 1'b0;
        bus.rxd_out  = 8'h00;
        model_reset();
        repeat (3) @(posedge clk_30M);
        #1 rst = 1'b1;
        check_en = 1'b1;

        @(negedge clk_30M);
        check_output("reset_txd", bus.txd_data, 8'hC3);
        check_output("reset_ctrl", bus.ctrl_reg, 8'h00);
        check_output("reset_wr_addr", {4'b0, bus.wr_addr}, 8'h00);
        check_output("reset_led", {7'b0, bus.led_state}, 8'h00);

        q = {8'h01, 8'h03, 8'h11, 8'h22, 8'h33};
        send_frame();
        check_output("wburst_txd0", txd_hist[0], 8'hA5);
        check_output("wburst_txd1", txd_hist[1], 8'hA5);
        check_output("wburst_txd2", txd_hist[2], 8'h11);
        check_output("wburst_txd4", txd_hist[4], 8'h33);
        check_output("wburst_last_addr", {4'b0, bus.wr_addr}, 8'h05);

        q = {8'h01, 8'h0E, 8'h77};
        send_frame();
        q = {8'h02, 8'h0E, 8'h00, 8'h00};
        send_frame();
        check_output("rburst_reg14", txd_hist[1], 8'h77);
        check_output("rburst_id", txd_hist[2], 8'h5A);
        check_output("rburst_wrap_reg0", txd_hist[3], 8'h00);

        q = {8'h01, 8'h0F, 8'h99, 8'h01};
        send_frame();
        check_output("led_on", {7'b0, bus.led_state}, 8'h01);
        check_output("id_write_addr", {4'b0, bus.wr_addr}, 8'h00);
        q = {8'h01, 8'h00, 8'h80};
        send_frame();
        check_output("led_off", {7'b0, bus.led_state}, 8'h00);
        check_output("ctrl_80", bus.ctrl_reg, 8'h80);

        q = {8'h07, 8'h00};
        send_frame();
        check_output("err_nak", txd_hist[0], 8'hEE);
        check_output("err_hold", txd_hist[1], 8'hEE);
        q = {8'h03};
        send_frame();
        check_output("status_sticky", txd_hist[0], 8'h11);
        q = {8'h03};
        send_frame();
        check_output("status_clear", txd_hist[0], 8'h10);

        q = {8'h01, 8'h05};
        send_frame();
        q = {8'h02, 8'h05, 8'h00};
        send_frame();
        check_output("trunc_reg5", txd_hist[1], 8'h33);

        frame_begin();
        apply_stimulus(8'h01, 1'b1);
        apply_stimulus(8'h06, 1'b1);
        apply_stimulus(8'hAA, 1'b1);
        apply_stimulus(8'hBB, 1'b1);
        @(posedge clk_30M); #1;
        rst    = 1'b0;
        bus.cs = 1'b1;
        model_reset();
        @(negedge clk_30M);
        check_output("midrst_txd", bus.txd_data, 8'hC3);
        check_output("midrst_ctrl", bus.ctrl_reg, 8'h00);
        @(posedge clk_30M); #1 rst = 1'b1;
        txd_hist.delete();
        apply_stimulus(8'h02, 1'b0);
        apply_stimulus(8'h03, 1'b0);
        check_output("idle_ignored", txd_hist[1], 8'hC3);
        q = {8'h02, 8'h03, 8'h00};
        send_frame();
        check_output("post_rst_reg3", txd_hist[1], 8'h00);
        check_output("post_rst_reg4", txd_hist[2], 8'h00);

        repeat (2) @(posedge clk_30M);
        check_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
